seq_logic_shift_unit: RTL
=========================

Name: seq_logic_shift_unit

Overview:
Parametrised, clocked successor to the combinational n-bit logic unit. It adds NOR, logical/arithmetic shifts and rotate to the logic operations, and registers the result. Shifts run iteratively, one bit position per cycle, under a start/busy/done handshake. It sits in the MIPS execute stage beside the ALU, and the control unit stalls the pipeline while busy is high.

Parameters:
n, 32, datapath width in bits (n >= 2)
SW, $clog2(n), shift-amount width (derived; not overridden)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled on rising clk edge when not busy
A  input  n  operand A (logic ops only)
B  input  n  operand B (logic ops; source operand for shifts/rotate)
sel  input  3  operation select
shamt  input  SW  shift/rotate amount, 0..n-1
OUT  output  n  registered result, held until next accepted start
busy  output  1  high while a shift/rotate is in progress
done  output  1  one-cycle pulse: OUT valid and new
zero  output  1  registered; high when OUT == 0

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, rst.
- sel encoding:
  - 000 A&B, 001 A|B, 010 A^B, 011 ~(A|B)
  - 100 SLL B, 101 SRL B, 110 SRA B (sign-fill from B[n-1]), 111 ROTR B
- FSM states: IDLE, SHIFT.
- rst asserted (any time, including mid-shift): state=IDLE, OUT=0, busy=0, done=0, zero=1, internal counter=0. Takes effect immediately, not at the next edge.
- IDLE with start=1 at edge k:
  - sel[2]=0, or sel[2]=1 with shamt=0: at edge k, OUT gets the logic result or B unchanged. done=1 during cycle k..k+1. State stays IDLE. Latency is 1 edge.
  - sel[2]=1 with shamt>0: at edge k, OUT<=B, count<=shamt, op latched, state->SHIFT, busy=1.
- SHIFT, each edge:
  - OUT shifts or rotates one position per the latched op; count decrements.
  - On the edge where count goes 1->0: state->IDLE, busy=0, done=1 for the following cycle.
  - Total latency is shamt+1 edges from the start edge to done visible.
- start while busy=1 is ignored. A, B, sel and shamt may change freely during SHIFT without effect.
- start in the cycle done is high is accepted (state is IDLE). done then pulses again for the new op. done never stays high more than one cycle unless back-to-back single-cycle ops are issued.
- zero is updated on every edge that updates OUT. It is combinationally equivalent to (OUT==0) but registered alongside OUT.
- No arithmetic carries. All results are exactly n bits, and SRA sign-fill uses the latched MSB at each step.
- With start=0 in IDLE: OUT, zero hold; done=0.

Test Plan:
1. Reset, then start with A=51, B=486, sel=000/001/010/011, one per cycle back-to-back -> OUT=34, 503, 469, 0xFFFFFE08. done high each cycle, busy=0, zero=0.
2. A=0xF0, B=0x0F, sel=000 -> OUT=0, zero=1, done pulses 1 cycle after start edge.
3. B=486, sel=100, shamt=4 -> busy high 4 cycles; done on 5th edge; OUT=7776. A start pulse injected mid-shift with sel=000 is ignored (OUT still 7776).
4. B=0x80000000, sel=110, shamt=31 -> done after 32 edges, OUT=0xFFFFFFFF. The same op with sel=101 -> OUT=0x00000001.
5. B=0x00000001, sel=111, shamt=1 -> OUT=0x80000000 after 2 edges. Then sel=101, shamt=0, B=0x1234 -> OUT=0x1234 in 1 edge, busy never high.
6. Start SLL shamt=20, assert rst asynchronously after 5 cycles (between edges) -> OUT=0, busy=0, done=0, zero=1 immediately. After release, a new A=4152, B=1553, sel=000 op -> OUT=16.

Source files
------------

// File: rtl/seq_logic_shift_unit.sv
// seq_logic_shift_unit: registered logic unit with iterative one-bit-per-cycle shift/rotate
module seq_logic_shift_unit #(
  parameter int n = 32,
  localparam int SW = $clog2(n)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [n-1:0]  A,
  input  logic [n-1:0]  B,
  input  logic [2:0]    sel,
  input  logic [SW-1:0] shamt,
  output logic [n-1:0]  OUT,
  output logic          busy,
  output logic          done,
  output logic          zero
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [SW-1:0] count;
  logic [1:0] op;
  logic [n-1:0] lres, ires, step;
  always_comb lres = sel[1] ? (sel[0] ? ~(A | B) : A ^ B) : (sel[0] ? A | B : A & B);
  always_comb ires = sel[2] ? B : lres;
  // SRA refills from the current MSB, which is the latched sign after the first load
  always_comb step = op == 2'b00 ? {OUT[n-2:0], 1'b0} :
                     op == 2'b01 ? {1'b0, OUT[n-1:1]} :
                     op == 2'b10 ? {OUT[n-1], OUT[n-1:1]} : {OUT[0], OUT[n-1:1]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      OUT <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      zero <= 1'b1;
      count <= '0;
      op <= '0;
    end else if (state == IDLE) begin
      done <= 1'b0;
      if (start) begin
        OUT <= ires;
        zero <= ires == '0;
        if (sel[2] && shamt != '0) begin
          count <= shamt;
          op <= sel[1:0];
          state <= SHIFT;
          busy <= 1'b1;
        end else done <= 1'b1;
      end
    end else begin
      OUT <= step;
      zero <= step == '0;
      count <= count - SW'(1);
      if (count == SW'(1)) begin
        state <= IDLE;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end
endmodule
